// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and default width for the multicycle ALU
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_MUL = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ALU: AND/OR/ADD/SUB/SLT/NOR with carry and overflow
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    // SLT shares the subtractor; its verdict is the true sign of A-B
    assign w_sub = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT);
    assign w_b   = w_sub ? ~b_i : b_i;
    assign w_sum = {1'b0, a_i} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf = (a_i[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);

    always_comb begin
        result_o   = '0;
        cout_o     = 1'b0;
        overflow_o = 1'b0;
        case (ctrl_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_NOR: result_o = ~(a_i | b_i);
            OP_ADD, OP_SUB: begin
                result_o   = w_sum[WIDTH-1:0];
                cout_o     = w_sum[WIDTH];
                overflow_o = w_ovf;
            end
            OP_SLT: result_o = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU top: request FSM, shift-add multiplier, registered results
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    alu_state_e         r_state;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_src2;
    logic [3:0]         r_ctrl;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_cout;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_core_result;
    logic               w_core_cout;
    logic               w_core_ovf;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i        (r_src1),
        .b_i        (r_src2),
        .ctrl_i     (r_ctrl),
        .result_o   (w_core_result),
        .cout_o     (w_core_cout),
        .overflow_o (w_core_ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_src1   <= '0;
            r_src2   <= '0;
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_src1   <= src1_i;
                        r_src2   <= src2_i;
                        r_ctrl   <= ctrl_i;
                        r_cnt    <= '0;
                        r_prod   <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, src1_i};
                        r_mplier <= src2_i;
                        r_busy   <= 1'b1;
                        r_state  <= (ctrl_i == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_core_result;
                    r_zero   <= (w_core_result == '0);
                    r_cout   <= w_core_cout;
                    r_ovf    <= w_core_ovf;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_MUL: begin
                    // WIDTH partial-product cycles, then one cycle to register the result
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        r_result <= r_prod[WIDTH-1:0];
                        r_zero   <= (r_prod[WIDTH-1:0] == '0);
                        r_cout   <= 1'b0;
                        r_ovf    <= |r_prod[2*WIDTH-1:WIDTH];
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_prod <= r_prod + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign result_o   = r_result;
    assign zero_o     = r_zero;
    assign cout_o     = r_cout;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle at WIDTH=8
module tb_alu_multicycle;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] src1;
    logic [7:0] src2;
    logic [3:0] ctrl;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       cout;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .src1_i     (src1),
        .src2_i     (src2),
        .ctrl_i     (ctrl),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .zero_o     (zero),
        .cout_o     (cout),
        .overflow_o (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge and follow it to its done pulse;
    // with spam set, start stays high with fresh operands until the done cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input logic [7:0] er,
                          input logic ez, input logic ec, input logic eo, input bit spam);
        int c;
        start = 1'b1;
        src1  = a;
        src2  = b;
        ctrl  = op;
        @(posedge clk);
        @(negedge clk);
        c = 1;
        if (spam) begin
            src1 = 8'($urandom);
            src2 = 8'($urandom);
            ctrl = 4'b0010;
        end else begin
            start = 1'b0;
        end
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
            if (spam) begin
                src1 = 8'($urandom);
                src2 = 8'($urandom);
            end
        end
        chk({tag, "_latency"}, 64'(c), 64'(exp_lat));
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_held"}, 64'(result), 64'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        src1  = '0;
        src2  = '0;
        ctrl  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ovf",  4'b0010, 8'h7F, 8'h01, 2, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sub_eq",   4'b0110, 8'h05, 8'h05, 2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("slt_neg",  4'b0111, 8'h80, 8'h01, 2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_pos",  4'b0111, 8'h05, 8'h03, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("and",      4'b0000, 8'hF0, 8'h3C, 2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or",       4'b0001, 8'hF0, 8'h0F, 2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("nor",      4'b1100, 8'hF0, 8'h0F, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 4'b0010, 8'hFF, 8'h01, 2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub_neg",  4'b0110, 8'h80, 8'h01, 2, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("mul_ovf",  4'b1000, 8'h10, 8'h10, 10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("mul_fit",  4'b1000, 8'h0F, 8'h0B, 10, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("mul_spam", 4'b1000, 8'h0D, 8'h07, 10, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset in the middle of a multiply
        start = 1'b1;
        ctrl  = 4'b1000;
        src1  = 8'hFF;
        src2  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_mul_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_zero", 64'(zero), 64'd0);
        chk("arst_cout", 64'(cout), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_hold_done", 64'(done), 64'd0);
        end
        rst = 1'b0;
        run_op("add_after_rst", 4'b0010, 8'h01, 8'h02, 2, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_stray_done", 64'(done), 64'd0);
        end

        run_op("undef_op", 4'b1111, 8'h12, 8'h34, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("undef_op3", 4'b0011, 8'h7F, 8'h7F, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
